seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Synthesizable, clocked scan controller for a 4-digit multiplexed 7-segment display.
- Replaces delay-based digit sequencing with a prescaled digit scan, dead-time blanking between digits, and optional leading-zero suppression.
- Accepts 16-bit hex values from upstream blocks (e.g. the divider result) through a valid/ready handshake, and swaps them in only at frame boundaries so a frame never mixes two values.

Parameters:
- DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- BLANK, 16: cycles at the start of each slot with all digits off; must satisfy 1 <= BLANK < DIV.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  scan enable; 0 blanks the display and holds the scan at its start point.
- lz_en  input  1  1 = blank leading zero digits.
- in_data  input  16  value to display; nibble k drives digit k, digit 0 = in_data[3:0].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  pending buffer is empty and can accept a value.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- dig  output  4  digit enables, one-hot active-high; dig[k] selects digit k.
- frame_done  output  1  one-cycle pulse when the digit-3 slot ends.

Behaviour:
- Async reset (rst=1, effective immediately, including mid-frame):
  - cnt=0, idx=0, disp=16'h0000, pend_full=0.
  - seg=0, dig=0, in_ready=1, frame_done=0.
- Prescaler:
  - cnt counts 0..DIV-1 while en=1; tick = (cnt==DIV-1).
  - On tick: cnt wraps to 0 and idx advances 0→1→2→3→0.
- en=0:
  - cnt and idx are forced to 0 on the next edge.
  - seg and dig are forced to 0.
  - frame_done stays 0.
  - The handshake and buffering still operate.
  - After en returns to 1, scanning restarts from the start of digit slot 0.
- Handshake:
  - in_ready = !pend_full.
  - Accept on posedge when in_valid && in_ready: pend <= in_data, pend_full <= 1.
  - in_data is ignored when not accepted.
- Frame swap:
  - Occurs on a tick with idx==3 and pend_full==1: disp <= pend, pend_full <= 0.
  - in_ready rises the following cycle.
  - If an accept coincides with that tick, it cannot happen (in_ready was 0). An accept on any other cycle lands in pend and is displayed from the next frame.
- frame_done: registered, 1 for exactly the cycle after each tick with idx==3 while en=1.
- Output stage (registered, latency 1 from state):
  - dig(t+1) = 0 if en=0 or cnt(t) < BLANK; otherwise onehot(idx(t)).
  - seg(t+1) = 0 when dig(t+1)=0 or the digit is suppressed; otherwise enc(disp nibble idx(t)).
- Leading-zero suppression (lz_en=1):
  - Digit k>0 is suppressed when disp[15:4k] == 0.
  - Digit 0 is never suppressed, so value 0 shows "0" on digit 0.
  - lz_en is sampled every cycle with no latching.
- Encoding enc (hex):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Widths:
  - cnt width = clog2(DIV); idx is 2 bits and wraps naturally.
  - No combinational path from inputs to outputs except in_ready from pend_full, which is registered state.

Test Plan (DIV=8, BLANK=2):
- Reset then en=1, no load → disp=0000:
  - dig=0000 for 2 cycles per slot, then 0001/0010/0100/1000 for 6 cycles each.
  - seg=3F on every lit digit.
  - frame_done pulses every 32 cycles.
- Load 16'h1A3F, lz_en=0:
  - in_ready drops the cycle after the accept.
  - From the next frame, digits 0..3 show seg 71, 4F, 77, 06.
  - in_ready rises the cycle after the frame_done tick.
- Second in_valid while pend_full=1 (value 16'hFFFF after 16'h1234):
  - Not accepted; in_ready=0 throughout.
  - Display becomes 1234 at the frame boundary.
  - 16'hFFFF is accepted only after in_ready returns to 1 and appears one frame later.
- lz_en=1:
  - disp=0x0040: digits 3 and 2 have dig active with seg=00; digit 1 shows 66; digit 0 shows 3F.
  - disp=0x0000: only digit 0 shows 3F.
- Deassert en mid-slot of digit 2:
  - Next cycle dig=0, seg=0, no frame_done.
  - Re-enable: 2 blank cycles, then dig=0001.
- Assert rst mid-frame with pend_full=1:
  - Outputs clear immediately (async), with in_ready=1.
  - After release, disp=0000 and the pending value is discarded.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Prescaled digit scan, per-slot blanking, leading-zero blanking, framed value swap.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lz_en,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_pend_full;
  logic          r_frame_done;
  logic [6:0]    r_seg;
  logic [3:0]    r_dig;

  logic          w_tick;
  logic          w_last;
  logic          w_accept;
  logic          w_swap;
  logic          w_lit;
  logic          w_sup;
  logic [3:0]    w_nib;
  logic [3:0]    w_onehot;
  logic [6:0]    w_enc;

  assign w_tick   = en && (r_cnt == C_LAST);
  assign w_last   = w_tick && (r_idx == 2'd3);
  assign w_accept = in_valid && !r_pend_full;
  assign w_swap   = w_last && r_pend_full;
  assign w_lit    = en && (r_cnt >= C_BLANK);

  assign in_ready   = !r_pend_full;
  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_done = r_frame_done;

  // Select the nibble, digit enable and suppression for the current slot
  always_comb begin
    w_nib    = r_disp[3:0];
    w_onehot = 4'b0001;
    w_sup    = 1'b0;
    unique case (r_idx)
      2'd0: begin
        w_nib    = r_disp[3:0];
        w_onehot = 4'b0001;
        w_sup    = 1'b0;
      end
      2'd1: begin
        w_nib    = r_disp[7:4];
        w_onehot = 4'b0010;
        w_sup    = lz_en && (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib    = r_disp[11:8];
        w_onehot = 4'b0100;
        w_sup    = lz_en && (r_disp[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib    = r_disp[15:12];
        w_onehot = 4'b1000;
        w_sup    = lz_en && (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  // Hex to segment pattern, {g,f,e,d,c,b,a}
  always_comb begin
    w_enc = 7'h00;
    unique case (w_nib)
      4'h0: w_enc = 7'h3F;
      4'h1: w_enc = 7'h06;
      4'h2: w_enc = 7'h5B;
      4'h3: w_enc = 7'h4F;
      4'h4: w_enc = 7'h66;
      4'h5: w_enc = 7'h6D;
      4'h6: w_enc = 7'h7D;
      4'h7: w_enc = 7'h07;
      4'h8: w_enc = 7'h7F;
      4'h9: w_enc = 7'h6F;
      4'hA: w_enc = 7'h77;
      4'hB: w_enc = 7'h7C;
      4'hC: w_enc = 7'h39;
      4'hD: w_enc = 7'h5E;
      4'hE: w_enc = 7'h79;
      4'hF: w_enc = 7'h71;
    endcase
  end

  // Slot prescaler and digit index; disable parks at slot 0 start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending buffer fills on handshake, drains into display at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 16'h0000;
      r_pend_full <= 1'b0;
      r_disp      <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_pend      <= in_data;
        r_pend_full <= 1'b1;
      end
      if (w_swap) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end
    end
  end

  // Registered digit/segment drive and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig        <= 4'b0000;
      r_seg        <= 7'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      r_dig        <= w_lit ? w_onehot : 4'b0000;
      r_seg        <= (w_lit && !w_sup) ? w_enc : 7'h00;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl, DIV=8 BLANK=2.
// Frame checks walk all 32 cycles of a frame against hand-written digit patterns.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        lz_en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int n_pass;
  int n_total;

  typedef struct {
    logic [15:0]     val;
    logic            lz;
    logic [3:0][6:0] s;
  } vec_t;

  vec_t tbl[7];

  seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lz_en      (lz_en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one frame starting right after a frame_done sample (or scan start)
  task automatic check_frame(input logic [3:0][6:0] s, input string tag);
    logic [3:0] ed;
    logic [6:0] es;
    logic       ef;
    for (int m = 0; m < 32; m++) begin
      step();
      if (m == 0) in_valid = 1'b0;
      ed = ((m % 8) < 2) ? 4'b0000 : 4'(1 << (m / 8));
      es = (ed != 4'b0000) ? s[m / 8] : 7'h00;
      ef = (m == 31);
      n_total++;
      if ({dig, seg, frame_done} == {ed, es, ef}) n_pass++;
      else $display("FAIL %s m=%0d: got dig=%b seg=%h fd=%b expected dig=%b seg=%h fd=%b",
                    tag, m, dig, seg, frame_done, ed, es, ef);
    end
  endtask

  task automatic wait_fd(output bit low);
    int n;
    low = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (!frame_done && in_ready) low = 1'b0;
    end while (!frame_done && n < 200);
    chk("fd_timeout", int'(frame_done), 1);
  endtask

  task automatic load(input logic [15:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_data  = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 16'h5555;
    chk("ready_drop", int'(in_ready), 0);
  endtask

  initial begin
    bit low;
    logic [3:0][6:0] zeros;
    logic [3:0][6:0] fs;
    bit quiet;

    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    en       = 1'b0;
    lz_en    = 1'b0;
    in_data  = 16'h0000;
    in_valid = 1'b0;
    zeros    = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    fs       = {7'h71, 7'h71, 7'h71, 7'h71};

    tbl[0] = '{16'h1A3F, 1'b0, {7'h06, 7'h77, 7'h4F, 7'h71}};
    tbl[1] = '{16'h0040, 1'b1, {7'h00, 7'h00, 7'h66, 7'h3F}};
    tbl[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[3] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    tbl[4] = '{16'h00A0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}};
    tbl[5] = '{16'h1000, 1'b1, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
    tbl[6] = '{16'h0203, 1'b1, {7'h00, 7'h5B, 7'h3F, 7'h4F}};

    step();
    step();
    chk("rst_outs", int'({dig, seg, frame_done}), 0);
    chk("rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    step();
    chk("idle_outs", int'({dig, seg, frame_done}), 0);

    en = 1'b1;
    check_frame(zeros, "frame0");
    check_frame(zeros, "frame1");

    foreach (tbl[i]) begin
      lz_en = tbl[i].lz;
      load(tbl[i].val);
      wait_fd(low);
      chk("ready_low", int'(low), 1);
      chk("ready_rise", int'(in_ready), 1);
      check_frame(tbl[i].s, $sformatf("vec%0d", i));
    end

    lz_en = 1'b0;
    load(16'h1234);
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    wait_fd(low);
    chk("busy_ready_low", int'(low), 1);
    chk("busy_ready_rise", int'(in_ready), 1);
    check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, "v1234");
    check_frame(fs, "vFFFF");

    for (int i = 0; i < 21; i++) step();
    chk("slot2_dig", int'(dig), 4'b0100);
    en = 1'b0;
    step();
    chk("dis_outs", int'({dig, seg, frame_done}), 0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({dig, seg, frame_done} != '0) quiet = 1'b0;
    end
    chk("dis_quiet", int'(quiet), 1);
    en = 1'b1;
    check_frame(fs, "reen");

    load(16'hABCD);
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_dig", int'(dig), 4'b0010);
    rst = 1'b1;
    #1;
    chk("async_outs", int'({dig, seg, frame_done}), 0);
    chk("async_ready", int'(in_ready), 1);
    step();
    step();
    chk("held_outs", int'({dig, seg, frame_done}), 0);
    rst = 1'b0;
    check_frame(zeros, "post_rst0");
    check_frame(zeros, "post_rst1");
    chk("post_rst_ready", int'(in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
